// File: rtl/seq_pkg.sv
// Shared types for the serial sequence path: generator FSM state encoding
// and the length-field width helper used by the generator and detectors.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } seq_state_e;

    // Width needed to hold a bit count of 0..width.
    function automatic int len_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_shifter.sv
// WIDTH-bit parallel-load, MSB-first shift register with a down-counting
// bit counter; last_bit_o marks the final bit of the current pass.
module seq_shifter
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = len_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             msb_o,
    output logic             last_bit_o
);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    // len_i is already clamped to 1..WIDTH, so len-1 never underflows.
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = data_i;
            cnt_d = len_i - LEN_W'(1);
        end else if (shift_i) begin
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb_o      = sh_q[WIDTH-1];
    assign last_bit_o = (cnt_q == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial frame transmitter: accepts a word on a valid/ready handshake and
// shifts len bits out MSB-first, repeating with an idle gap between passes.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a frame; load_ready high one cycle later
//   ST_SHIFT | one frame bit per cycle from the shifter
//   ST_GAP   | GAP idle cycles between repeats (output 0, not valid)
module sequence_generator
    import seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 4,
    parameter  int GAP   = 2,
    localparam int LEN_W = len_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [CNT_W-1:0] load_repeat,
    output logic             sequence_out,
    output logic             out_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             load_ready_q;
    logic             seq_out_q;
    logic             out_valid_q;
    logic             frame_done_q;
    logic             busy_q;

    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_data;
    logic [LEN_W-1:0] sh_len;
    logic             sh_msb;
    logic             sh_last;

    assign accept = (state_q == ST_IDLE) && load_valid && load_ready_q;

    always_comb begin
        len_eff = load_len;
        if (load_len == '0 || load_len > LEN_W'(WIDTH)) begin
            len_eff = LEN_W'(WIDTH);
        end
    end

    seq_shifter #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .load_i     (sh_load),
        .shift_i    (sh_shift),
        .data_i     (sh_data),
        .len_i      (sh_len),
        .msb_o      (sh_msb),
        .last_bit_o (sh_last)
    );

    always_comb begin
        state_d  = state_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
        data_d   = data_q;
        len_d    = len_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_data  = data_q;
        sh_len   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = load_data;
                    len_d   = len_eff;
                    rep_d   = load_repeat;
                    sh_load = 1'b1;
                    sh_data = load_data;
                    sh_len  = len_eff;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!sh_last) begin
                    sh_shift = 1'b1;
                end else if (rep_q != '0) begin
                    // Reload from the captured word; with GAP=0 stay in SHIFT.
                    rep_d   = rep_q - CNT_W'(1);
                    sh_load = 1'b1;
                    if (GAP > 0) begin
                        gap_d   = GAP_W'(GAP - 1);
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered views of the cycle the FSM has just finished,
    // which gives the one-cycle latency from acceptance to the first bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rep_q        <= '0;
            gap_q        <= '0;
            data_q       <= '0;
            len_q        <= '0;
            load_ready_q <= 1'b0;
            seq_out_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rep_q        <= rep_d;
            gap_q        <= gap_d;
            data_q       <= data_d;
            len_q        <= len_d;
            load_ready_q <= (state_q == ST_IDLE) && !accept;
            seq_out_q    <= (state_q == ST_SHIFT) && sh_msb;
            out_valid_q  <= (state_q == ST_SHIFT);
            frame_done_q <= (state_q == ST_SHIFT) && sh_last && (rep_q == '0);
            busy_q       <= (state_q != ST_IDLE);
        end
    end

    assign load_ready   = load_ready_q;
    assign sequence_out = seq_out_q;
    assign out_valid    = out_valid_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule
